// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: depth, index width and op type encodings.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;

  localparam logic [1:0] TYPE_NORMAL = 2'd0;
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_JALR   = 2'd2;
  localparam logic [1:0] TYPE_STORE  = 2'd3;

  // Branch writeback carries the actual direction in bit 0.
  function automatic logic is_mispredict(logic [1:0] ty, logic taken, logic pred);
    return (ty == TYPE_BRANCH) && (taken != pred);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry reorder buffer: in-order issue, out-of-order writeback, in-order commit,
// with a one-cycle deferred flush on branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_dest,
  input  logic [1:0]           issue_type,
  input  logic                 issue_pred_jump,
  input  logic [31:0]          issue_next_pc,
  input  logic [31:0]          issue_alt_pc,
  output logic [3:0]           issue_rename,
  output logic                 full,
  input  logic                 alu_wb_valid,
  input  logic [3:0]           alu_wb_rename,
  input  logic [31:0]          alu_wb_value,
  input  logic                 lsb_wb_valid,
  input  logic [3:0]           lsb_wb_rename,
  input  logic [31:0]          lsb_wb_value,
  output logic                 commit_flag,
  output logic [31:0]          commit_value,
  output logic [3:0]           commit_rename,
  output logic [4:0]           commit_dest,
  output logic                 commit_is_jalr,
  output logic [31:0]          jalr_next_pc,
  output logic                 commit_is_branch,
  output logic                 commit_is_store,
  output logic                 cdb_flush,
  output logic [31:0]          flush_pc
);

  logic [ROB_DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, pred_q, pred_d;
  logic [1:0]           type_q    [ROB_DEPTH];
  logic [1:0]           type_d    [ROB_DEPTH];
  logic [4:0]           dest_q    [ROB_DEPTH];
  logic [4:0]           dest_d    [ROB_DEPTH];
  logic [31:0]          value_q   [ROB_DEPTH];
  logic [31:0]          value_d   [ROB_DEPTH];
  logic [31:0]          next_pc_q [ROB_DEPTH];
  logic [31:0]          next_pc_d [ROB_DEPTH];
  logic [31:0]          alt_pc_q  [ROB_DEPTH];
  logic [31:0]          alt_pc_d  [ROB_DEPTH];

  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_IDX_W:0]   count_q, count_d;
  logic                 flush_pending_q, flush_pending_d;
  logic                 do_issue, do_commit;

  logic        commit_flag_q, commit_flag_d, cdb_flush_q, cdb_flush_d;
  logic [31:0] commit_value_q, commit_value_d, jalr_next_pc_q, jalr_next_pc_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic [3:0]  commit_rename_q, commit_rename_d;
  logic [4:0]  commit_dest_q, commit_dest_d;
  logic        commit_is_jalr_q, commit_is_jalr_d;
  logic        commit_is_branch_q, commit_is_branch_d;
  logic        commit_is_store_q, commit_is_store_d;

  assign full         = (count_q == (ROB_IDX_W + 1)'(ROB_DEPTH));
  assign issue_rename = tail_q;

  assign do_issue  = rdy && issue_valid && !full && !flush_pending_q;
  assign do_commit = rdy && (count_q != '0) && valid_q[head_q] && ready_q[head_q]
                     && !flush_pending_q;

  always_comb begin
    valid_d            = valid_q;
    ready_d            = ready_q;
    pred_d             = pred_q;
    type_d             = type_q;
    dest_d             = dest_q;
    value_d            = value_q;
    next_pc_d          = next_pc_q;
    alt_pc_d           = alt_pc_q;
    head_d             = head_q;
    tail_d             = tail_q;
    count_d            = count_q;
    flush_pending_d    = flush_pending_q;
    commit_flag_d      = 1'b0;
    cdb_flush_d        = 1'b0;
    commit_value_d     = commit_value_q;
    commit_rename_d    = commit_rename_q;
    commit_dest_d      = commit_dest_q;
    commit_is_jalr_d   = commit_is_jalr_q;
    commit_is_branch_d = commit_is_branch_q;
    commit_is_store_d  = commit_is_store_q;
    jalr_next_pc_d     = jalr_next_pc_q;
    flush_pc_d         = flush_pc_q;

    if (rdy && flush_pending_q) begin
      valid_d         = '0;
      ready_d         = '0;
      head_d          = '0;
      tail_d          = '0;
      count_d         = '0;
      flush_pending_d = 1'b0;
      cdb_flush_d     = 1'b1;
    end else if (rdy) begin
      // LSB first so an ALU writeback to the same rename overrides it.
      if (lsb_wb_valid && valid_q[lsb_wb_rename]) begin
        ready_d[lsb_wb_rename] = 1'b1;
        value_d[lsb_wb_rename] = lsb_wb_value;
      end
      if (alu_wb_valid && valid_q[alu_wb_rename]) begin
        ready_d[alu_wb_rename] = 1'b1;
        value_d[alu_wb_rename] = alu_wb_value;
      end
      if (do_commit) begin
        commit_flag_d      = 1'b1;
        commit_value_d     = value_q[head_q];
        commit_rename_d    = head_q;
        commit_dest_d      = dest_q[head_q];
        commit_is_jalr_d   = (type_q[head_q] == TYPE_JALR);
        commit_is_branch_d = (type_q[head_q] == TYPE_BRANCH);
        commit_is_store_d  = (type_q[head_q] == TYPE_STORE);
        jalr_next_pc_d     = next_pc_q[head_q];
        valid_d[head_q]    = 1'b0;
        ready_d[head_q]    = 1'b0;
        head_d             = head_q + ROB_IDX_W'(1);
        if (is_mispredict(type_q[head_q], value_q[head_q][0], pred_q[head_q])) begin
          flush_pending_d = 1'b1;
          flush_pc_d      = alt_pc_q[head_q];
        end
      end
      if (do_issue) begin
        valid_d[tail_q]   = 1'b1;
        ready_d[tail_q]   = 1'b0;
        pred_d[tail_q]    = issue_pred_jump;
        type_d[tail_q]    = issue_type;
        dest_d[tail_q]    = issue_dest;
        next_pc_d[tail_q] = issue_next_pc;
        alt_pc_d[tail_q]  = issue_alt_pc;
        tail_d            = tail_q + ROB_IDX_W'(1);
      end
      count_d = count_q + (ROB_IDX_W + 1)'(do_issue) - (ROB_IDX_W + 1)'(do_commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      ready_q            <= '0;
      pred_q             <= '0;
      type_q             <= '{default: '0};
      dest_q             <= '{default: '0};
      value_q            <= '{default: '0};
      next_pc_q          <= '{default: '0};
      alt_pc_q           <= '{default: '0};
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      flush_pending_q    <= 1'b0;
      commit_flag_q      <= 1'b0;
      cdb_flush_q        <= 1'b0;
      commit_value_q     <= '0;
      commit_rename_q    <= '0;
      commit_dest_q      <= '0;
      commit_is_jalr_q   <= 1'b0;
      commit_is_branch_q <= 1'b0;
      commit_is_store_q  <= 1'b0;
      jalr_next_pc_q     <= '0;
      flush_pc_q         <= '0;
    end else begin
      valid_q            <= valid_d;
      ready_q            <= ready_d;
      pred_q             <= pred_d;
      type_q             <= type_d;
      dest_q             <= dest_d;
      value_q            <= value_d;
      next_pc_q          <= next_pc_d;
      alt_pc_q           <= alt_pc_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      flush_pending_q    <= flush_pending_d;
      commit_flag_q      <= commit_flag_d;
      cdb_flush_q        <= cdb_flush_d;
      commit_value_q     <= commit_value_d;
      commit_rename_q    <= commit_rename_d;
      commit_dest_q      <= commit_dest_d;
      commit_is_jalr_q   <= commit_is_jalr_d;
      commit_is_branch_q <= commit_is_branch_d;
      commit_is_store_q  <= commit_is_store_d;
      jalr_next_pc_q     <= jalr_next_pc_d;
      flush_pc_q         <= flush_pc_d;
    end
  end

  assign commit_flag      = commit_flag_q;
  assign commit_value     = commit_value_q;
  assign commit_rename    = commit_rename_q;
  assign commit_dest      = commit_dest_q;
  assign commit_is_jalr   = commit_is_jalr_q;
  assign jalr_next_pc     = jalr_next_pc_q;
  assign commit_is_branch = commit_is_branch_q;
  assign commit_is_store  = commit_is_store_q;
  assign cdb_flush        = cdb_flush_q;
  assign flush_pc         = flush_pc_q;

endmodule
